// File: rtl/axi_lite_kernel_scheduler.sv
// AXI4-Lite global control registers and job dispatcher for a multi-kernel action.
// Holds manager start, init address, interrupt status/enable, kernel disable and
// job counters; grants job_start requests to idle, enabled kernels.
module axi_lite_kernel_scheduler #(
    parameter int KERNEL_NUM = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int ARB_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  manager_start,
    output logic [63:0]           init_addr,
    output logic                  new_job,
    output logic                  job_done,
    input  logic                  job_start,
    output logic [KERNEL_NUM-1:0] kernel_start,
    input  logic [KERNEL_NUM-1:0] kernel_complete,
    input  logic [31:0]           i_action_type,
    output logic                  o_interrupt
);
    localparam int LGW = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
    localparam logic [31:0] KMASK    = (32'h1 << KERNEL_NUM) - 32'h1;
    localparam logic [31:0] IRQ_MASK = KMASK | 32'h8000_0000;
    localparam logic [31:0] UNMAPPED = 32'h5A5A_A5A5;
    localparam logic [KERNEL_NUM-1:0] ONE = KERNEL_NUM'(1'b1);

    // Expand byte strobes into a bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
        return m;
    endfunction

    // Number of set bits in a per-kernel vector.
    function automatic logic [31:0] popcount(input logic [KERNEL_NUM-1:0] v);
        logic [31:0] c;
        c = 32'h0;
        for (int i = 0; i < KERNEL_NUM; i++) c = c + 32'(v[i]);
        return c;
    endfunction

    // Zero-extend a per-kernel vector to a register word.
    function automatic logic [31:0] ext(input logic [KERNEL_NUM-1:0] v);
        return {{(32-KERNEL_NUM){1'b0}}, v};
    endfunction

    // Kernel index reached by stepping off positions past base, wrapping.
    function automatic int rr_index(input int base, input int off);
        int s;
        s = base + off;
        return (s >= KERNEL_NUM) ? s - KERNEL_NUM : s;
    endfunction

    logic                  wr_ready_q, wr_ready_d, bvalid_q, bvalid_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           status_q, status_d, enable_q, enable_d;
    logic                  ms_q, ms_d;
    logic [31:0]           hi_q, hi_d, lo_q, lo_d;
    logic [KERNEL_NUM-1:0] busy_q, busy_d, disable_q, disable_d;
    logic [KERNEL_NUM-1:0] prev_q, prev_d, ks_q, ks_d;
    logic [31:0]           disp_q, disp_d, comp_q, comp_d;
    logic [LGW-1:0]        last_grant_q, last_grant_d, grant_idx_s;
    logic                  irq_q, irq_d;

    logic                  wr_en_s, rd_en_s, go_s, miss_s, clear_s, unused_s;
    logic [7:0]            waddr_s;
    logic [31:0]           wmask_s, wbits_s, w1c_s, rd_mux_s;
    logic [KERNEL_NUM-1:0] pe_s, eligible_s, grant_s;

    assign wr_en_s    = wr_ready_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_en_s    = arready_q & s_axi_arvalid;
    assign waddr_s    = s_axi_awaddr[7:0];
    assign wmask_s    = strb_mask(s_axi_wstrb);
    assign wbits_s    = s_axi_wdata & wmask_s;
    assign pe_s       = ~prev_q & kernel_complete;
    assign eligible_s = ~busy_q & ~disable_q;
    assign go_s       = job_start & (|eligible_s);
    assign miss_s     = job_start & ~(|eligible_s);
    assign grant_s    = go_s ? (ONE << grant_idx_s) : '0;
    assign unused_s   = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[ADDR_WIDTH-1:8],
                          s_axi_araddr[ADDR_WIDTH-1:8]};

    // Grant selection: highest eligible index, or nearest eligible after last grant.
    always_comb begin
        grant_idx_s = last_grant_q;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < KERNEL_NUM; i++) begin
                grant_idx_s = eligible_s[LGW'(i)] ? LGW'(i) : grant_idx_s;
            end
        end else begin
            for (int i = KERNEL_NUM; i >= 1; i--) begin
                grant_idx_s = eligible_s[LGW'(rr_index(int'(last_grant_q), i))]
                            ? LGW'(rr_index(int'(last_grant_q), i)) : grant_idx_s;
            end
        end
    end

    // Register read multiplexer, sampled on the AR handshake.
    always_comb begin
        case (s_axi_araddr[7:0])
            8'h10:   rd_mux_s = i_action_type;
            8'h30:   rd_mux_s = status_q;
            8'h34:   rd_mux_s = enable_q;
            8'h38:   rd_mux_s = {31'h0, ms_q};
            8'h3C:   rd_mux_s = hi_q;
            8'h40:   rd_mux_s = lo_q;
            8'h44:   rd_mux_s = ext(busy_q);
            8'h48:   rd_mux_s = disp_q;
            8'h4C:   rd_mux_s = comp_q;
            8'h50:   rd_mux_s = ext(disable_q);
            default: rd_mux_s = UNMAPPED;
        endcase
    end

    // Next state for handshakes, registers, dispatch state and counters.
    always_comb begin
        wr_ready_d = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~wr_ready_q;
        bvalid_d   = wr_en_s ? 1'b1 : (s_axi_bready ? 1'b0 : bvalid_q);
        rvalid_d   = rd_en_s ? 1'b1 : (s_axi_rready ? 1'b0 : rvalid_q);
        arready_d  = ~rvalid_d;
        rdata_d    = rd_en_s ? rd_mux_s : rdata_q;
        enable_d   = enable_q;
        ms_d       = ms_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        disable_d  = disable_q;
        w1c_s      = 32'h0;
        clear_s    = 1'b0;
        if (wr_en_s) begin
            case (waddr_s)
                8'h30: w1c_s = wbits_s;
                8'h34: enable_d = ((enable_q & ~wmask_s) | wbits_s) & IRQ_MASK;
                8'h38: begin
                    ms_d    = wmask_s[0] ? s_axi_wdata[0] : ms_q;
                    clear_s = wbits_s[1];
                end
                8'h3C: hi_d = (hi_q & ~wmask_s) | wbits_s;
                8'h40: lo_d = (lo_q & ~wmask_s) | wbits_s;
                8'h50: disable_d = (disable_q & ~wmask_s[KERNEL_NUM-1:0])
                                 | wbits_s[KERNEL_NUM-1:0];
                default: w1c_s = 32'h0;
            endcase
        end else begin
            w1c_s = 32'h0;
        end
        // A completion edge or dispatch miss wins over a simultaneous W1C.
        status_d     = ((status_q & ~w1c_s) | ext(pe_s) | {miss_s, 31'h0}) & IRQ_MASK;
        busy_d       = (busy_q & ~pe_s) | grant_s;
        ks_d         = grant_s;
        last_grant_d = go_s ? grant_idx_s : last_grant_q;
        disp_d       = clear_s ? 32'h0 : disp_q + 32'(go_s);
        comp_d       = clear_s ? 32'h0 : comp_q + popcount(pe_s);
        prev_d       = kernel_complete;
        irq_d        = |(status_q & enable_q);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ready_q   <= 1'b0;
            bvalid_q     <= 1'b0;
            arready_q    <= 1'b1;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'h0;
            status_q     <= 32'h0;
            enable_q     <= 32'h0;
            ms_q         <= 1'b0;
            hi_q         <= 32'h0;
            lo_q         <= 32'h0;
            busy_q       <= '0;
            disable_q    <= '0;
            prev_q       <= '1;
            ks_q         <= '0;
            disp_q       <= 32'h0;
            comp_q       <= 32'h0;
            last_grant_q <= LGW'(KERNEL_NUM - 1);
            irq_q        <= 1'b0;
        end else begin
            wr_ready_q   <= wr_ready_d;
            bvalid_q     <= bvalid_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            status_q     <= status_d;
            enable_q     <= enable_d;
            ms_q         <= ms_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            busy_q       <= busy_d;
            disable_q    <= disable_d;
            prev_q       <= prev_d;
            ks_q         <= ks_d;
            disp_q       <= disp_d;
            comp_q       <= comp_d;
            last_grant_q <= last_grant_d;
            irq_q        <= irq_d;
        end
    end

    assign s_axi_awready = wr_ready_q;
    assign s_axi_wready  = wr_ready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign manager_start = ms_q;
    assign init_addr     = {hi_q, lo_q};
    assign new_job       = |eligible_s;
    assign job_done      = ~(|busy_q);
    assign kernel_start  = ks_q;
    assign o_interrupt   = irq_q;
endmodule

// File: tb/tb_axi_lite_kernel_scheduler.sv
// Bench for axi_lite_kernel_scheduler: a fixed-priority and a round-robin
// instance share all inputs and are checked against a register-level model.
module tb_axi_lite_kernel_scheduler;
    localparam int K = 8;
    localparam logic [31:0] ACT = 32'hC0DE_0042;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, awvalid, wvalid, bready, arvalid, rready, job_start;
    logic [31:0] awaddr, araddr, wdata;
    logic [3:0]  wstrb;
    logic [2:0]  prot;
    logic [K-1:0] kc;
    logic [1:0]  awready, wready, bvalid, arready, rvalid, ms, new_job, job_done, irq;
    logic [1:0]  bresp [2];
    logic [1:0]  rresp [2];
    logic [31:0] rdata [2];
    logic [63:0] iaddr [2];
    logic [K-1:0] kstart [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_lite_kernel_scheduler #(.KERNEL_NUM(K), .ADDR_WIDTH(32), .ARB_MODE(g)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .s_axi_awvalid(awvalid), .s_axi_awready(awready[g]), .s_axi_awaddr(awaddr),
            .s_axi_awprot(prot), .s_axi_wvalid(wvalid), .s_axi_wready(wready[g]),
            .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_bvalid(bvalid[g]),
            .s_axi_bready(bready), .s_axi_bresp(bresp[g]), .s_axi_arvalid(arvalid),
            .s_axi_arready(arready[g]), .s_axi_araddr(araddr), .s_axi_arprot(prot),
            .s_axi_rvalid(rvalid[g]), .s_axi_rready(rready), .s_axi_rdata(rdata[g]),
            .s_axi_rresp(rresp[g]), .manager_start(ms[g]), .init_addr(iaddr[g]),
            .new_job(new_job[g]), .job_done(job_done[g]), .job_start(job_start),
            .kernel_start(kstart[g]), .kernel_complete(kc), .i_action_type(ACT),
            .o_interrupt(irq[g])
        );
    end

    int errs = 0;
    int checks = 0;
    logic run_chk = 1'b0;
    logic wr_now = 1'b0;
    logic rd_now = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (index 0 = fixed, 1 = round-robin) -----
    logic [K-1:0] m_busy [2];
    logic [K-1:0] m_ks [2];
    logic [31:0]  m_status [2];
    logic [31:0]  m_disp [2];
    logic [31:0]  m_comp [2];
    logic [31:0]  m_rexp [2];
    int           m_last [2];
    logic         m_irq [2];
    logic [K-1:0] m_prev, m_dis;
    logic [31:0]  m_en, m_hi, m_lo;
    logic         m_ms;

    function automatic logic [31:0] bytes_of(input logic [3:0] s);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) r = r | (32'hFF << (8 * b));
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int m, input logic [7:0] a);
        case (a)
            8'h10:   return ACT;
            8'h30:   return m_status[m];
            8'h34:   return m_en;
            8'h38:   return {31'h0, m_ms};
            8'h3C:   return m_hi;
            8'h40:   return m_lo;
            8'h44:   return {24'h0, m_busy[m]};
            8'h48:   return m_disp[m];
            8'h4C:   return m_comp[m];
            8'h50:   return {24'h0, m_dis};
            default: return 32'h5A5A_A5A5;
        endcase
    endfunction

    // Kernel picked from eligible set, -1 when none.
    function automatic int pick(input int m, input logic [K-1:0] elig);
        int r;
        r = -1;
        if (m == 0) begin
            for (int i = K - 1; i >= 0 && r < 0; i--) if (elig[i]) r = i;
        end else begin
            for (int s = 1; s <= K && r < 0; s++) if (elig[(m_last[m] + s) % K]) r = (m_last[m] + s) % K;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_busy[m] = '0; m_ks[m] = '0; m_status[m] = 32'h0; m_disp[m] = 32'h0;
            m_comp[m] = 32'h0; m_rexp[m] = 32'h0; m_last[m] = K - 1; m_irq[m] = 1'b0;
        end
        m_prev = '1; m_dis = '0; m_en = 32'h0; m_hi = 32'h0; m_lo = 32'h0; m_ms = 1'b0;
    endtask

    task automatic model_step();
        logic [K-1:0] pe, gb;
        logic [31:0]  clr, bm;
        logic         clr_cnt, miss;
        int           g;
        if (!rst_n) begin
            model_reset();
        end else begin
            pe = ~m_prev & kc;
            bm = bytes_of(wstrb);
            clr = (wr_now && awaddr[7:0] == 8'h30) ? (wdata & bm) : 32'h0;
            clr_cnt = wr_now && awaddr[7:0] == 8'h38 && wstrb[0] && wdata[1];
            for (int m = 0; m < 2; m++) begin
                if (rd_now) m_rexp[m] = m_read(m, araddr[7:0]);
                g = job_start ? pick(m, ~m_busy[m] & ~m_dis) : -1;
                miss = job_start && (g < 0);
                m_irq[m] = |(m_status[m] & m_en);
                m_status[m] = (m_status[m] & ~clr) | {24'h0, pe} | (miss ? 32'h8000_0000 : 32'h0);
                gb = (g >= 0) ? (8'h01 << g) : 8'h00;
                m_busy[m] = (m_busy[m] & ~pe) | gb;
                m_ks[m] = gb;
                if (g >= 0) m_last[m] = g;
                if (clr_cnt) begin
                    m_disp[m] = 32'h0;
                    m_comp[m] = 32'h0;
                end else begin
                    m_disp[m] = m_disp[m] + ((g >= 0) ? 32'd1 : 32'd0);
                    m_comp[m] = m_comp[m] + 32'($countones(pe));
                end
            end
            if (wr_now) begin
                case (awaddr[7:0])
                    8'h34: m_en = ((m_en & ~bm) | (wdata & bm)) & 32'h8000_00FF;
                    8'h38: if (wstrb[0]) m_ms = wdata[0];
                    8'h3C: m_hi = (m_hi & ~bm) | (wdata & bm);
                    8'h40: m_lo = (m_lo & ~bm) | (wdata & bm);
                    8'h50: m_dis = (m_dis & ~bm[7:0]) | (wdata[7:0] & bm[7:0]);
                    default: ;
                endcase
            end
            m_prev = kc;
        end
    endtask

    initial model_reset();
    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of both instances' outputs against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n && run_chk) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("kernel_start%0d", m), kstart[m], m_ks[m]);
                chk($sformatf("o_interrupt%0d", m), irq[m], m_irq[m]);
                chk($sformatf("new_job%0d", m), new_job[m], |(~m_busy[m] & ~m_dis));
                chk($sformatf("job_done%0d", m), job_done[m], m_busy[m] == '0);
                chk($sformatf("manager_start%0d", m), ms[m], m_ms);
                chk($sformatf("init_addr%0d", m), iaddr[m], {m_hi, m_lo});
            end
        end
    end

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = {24'h0, a}; wdata = d; wstrb = s;
        @(negedge clk);
        chk("awready", awready, 2'b11);
        chk("wready", wready, 2'b11);
        wr_now = 1'b1;
        @(negedge clk);
        wr_now = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("awready_pulse", awready, 2'b00);
        chk("bvalid_rise", bvalid, 2'b11);
        @(negedge clk);
        chk("bvalid_hold", bvalid, 2'b11);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 2'b00);
        chk("bresp", {bresp[1], bresp[0]}, 4'h0);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d0, output logic [31:0] d1);
        @(negedge clk);
        chk("arready_idle", arready, 2'b11);
        arvalid = 1'b1; araddr = {24'h0, a}; rd_now = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; rd_now = 1'b0;
        chk("rvalid_rise", rvalid, 2'b11);
        chk("arready_busy", arready, 2'b00);
        chk($sformatf("rdata%0h_fixed", a), rdata[0], m_rexp[0]);
        chk($sformatf("rdata%0h_rr", a), rdata[1], m_rexp[1]);
        d0 = rdata[0]; d1 = rdata[1];
        @(negedge clk);
        chk("rvalid_hold", rvalid, 2'b11);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_drop", rvalid, 2'b00);
        chk("rresp", {rresp[1], rresp[0]}, 4'h0);
    endtask

    task automatic read_lit(input logic [7:0] a, input logic [31:0] e0, input logic [31:0] e1);
        logic [31:0] d0, d1;
        axi_read(a, d0, d1);
        chk($sformatf("lit%0h_fixed", a), d0, e0);
        chk($sformatf("lit%0h_rr", a), d1, e1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0;
        rready = 1'b0; job_start = 1'b0; awaddr = 32'h0; araddr = 32'h0; wdata = 32'h0;
        wstrb = 4'h0; prot = 3'h0; kc = '0;
        repeat (3) @(negedge clk);
        chk("rst_arready", arready, 2'b11);
        chk("rst_awready", awready, 2'b00);
        chk("rst_bvalid", bvalid, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_rdata", {rdata[1], rdata[0]}, 64'h0);
        chk("rst_kstart", {kstart[1], kstart[0]}, 16'h0);
        chk("rst_irq", irq, 2'b00);
        chk("rst_new_job", new_job, 2'b11);
        chk("rst_job_done", job_done, 2'b11);
        chk("rst_init_addr", iaddr[0], 64'h0);
        rst_n = 1'b1;
        run_chk = 1'b1;

        read_lit(8'h10, ACT, ACT);
        read_lit(8'h38, 32'h0, 32'h0);
        read_lit(8'h44, 32'h0, 32'h0);
        read_lit(8'h60, 32'h5A5A_A5A5, 32'h5A5A_A5A5);

        axi_write(8'h40, 32'h89AB_CDEF, 4'h3);
        axi_write(8'h3C, 32'h0123_4567, 4'hF);
        chk("init_addr_lit", iaddr[0], 64'h0123_4567_0000_CDEF);
        axi_write(8'h38, 32'h1, 4'hF);
        chk("manager_start_lit", ms, 2'b11);

        // Nine consecutive dispatch requests into eight kernels.
        @(negedge clk);
        job_start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("fixed_grant%0d", i), kstart[0], (i < 8) ? (8'h80 >> i) : 8'h00);
            chk($sformatf("rr_grant%0d", i), kstart[1], (i < 8) ? (8'h01 << i) : 8'h00);
            if (i == 8) job_start = 1'b0;
        end
        chk("job_done_all_busy", job_done, 2'b00);
        read_lit(8'h48, 32'd8, 32'd8);
        read_lit(8'h30, 32'h8000_0000, 32'h8000_0000);
        axi_write(8'h30, 32'h8000_0000, 4'hF);

        // Simultaneous completion of kernels 0 and 2 with interrupts enabled.
        axi_write(8'h34, 32'h5, 4'hF);
        @(negedge clk);
        kc = 8'h05;
        repeat (3) @(negedge clk);
        chk("irq_lit", irq, 2'b11);
        read_lit(8'h30, 32'h5, 32'h5);
        read_lit(8'h4C, 32'd2, 32'd2);

        // W1C of bit 0 on the same edge as a new kernel-0 completion.
        kc = 8'h04;
        fork
            axi_write(8'h30, 32'h1, 4'hF);
            begin
                @(negedge clk);
                @(negedge clk);
                kc = 8'h05;
            end
        join
        read_lit(8'h30, 32'h5, 32'h5);
        read_lit(8'h4C, 32'd3, 32'd3);
        axi_write(8'h30, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        chk("irq_cleared", irq, 2'b00);
        read_lit(8'h30, 32'h0, 32'h0);

        // Reset while a read response is pending.
        @(negedge clk);
        arvalid = 1'b1; araddr = 32'h10;
        @(negedge clk);
        arvalid = 1'b0;
        chk("pre_reset_rvalid", rvalid, 2'b11);
        #1 rst_n = 1'b0;
        kc = '0;
        #1 chk("reset_drops_rvalid", rvalid, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Grants with kernel 1 disabled and completions in between.
        axi_write(8'h50, 32'h2, 4'hF);
        @(negedge clk); job_start = 1'b1;
        @(negedge clk); job_start = 1'b0;
        chk("rr_first", kstart[1], 8'h01);
        chk("fixed_first", kstart[0], 8'h80);
        kc = 8'h01;
        @(negedge clk); job_start = 1'b1;
        @(negedge clk); job_start = 1'b0;
        chk("rr_second", kstart[1], 8'h04);
        chk("fixed_second", kstart[0], 8'h40);
        kc = 8'h05;
        @(negedge clk); job_start = 1'b1;
        @(negedge clk); job_start = 1'b0;
        chk("rr_third", kstart[1], 8'h08);
        chk("fixed_third", kstart[0], 8'h20);
        read_lit(8'h44, 32'hE0, 32'h08);
        axi_write(8'h50, 32'h0A, 4'h1);
        read_lit(8'h44, 32'hE0, 32'h08);

        // Counter clear on the same edge as a dispatch.
        fork
            axi_write(8'h38, 32'h3, 4'h1);
            begin
                @(negedge clk);
                @(negedge clk);
                job_start = 1'b1;
                @(negedge clk);
                job_start = 1'b0;
            end
        join
        read_lit(8'h48, 32'h0, 32'h0);
        read_lit(8'h4C, 32'h0, 32'h0);
        read_lit(8'h38, 32'h1, 32'h1);

        repeat (2) @(negedge clk);
        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
